// File: rtl/upmixer_if.sv
// Baseband-in / DAC-out bundle for the upmixer.
//   in_valid, I_in, Q_in      : baseband sample offered by the modulator
//   in_ready                  : strobe, sample taken this cycle
//   cos_carrier, sin_carrier  : signed 8-bit carrier (+127 = 1.0)
//   dac_out, dac_valid        : mixed real output sample and its update flag
//   underrun                  : in_ready fired while no sample was offered
// master = modulator/carrier side, slave = upmixer.
interface upmixer_if #(
    parameter int NIN  = 16,
    parameter int NOUT = 16
);
    logic                   in_valid;
    logic signed [NIN-1:0]  I_in;
    logic signed [NIN-1:0]  Q_in;
    logic                   in_ready;
    logic signed [7:0]      cos_carrier;
    logic signed [7:0]      sin_carrier;
    logic signed [NOUT-1:0] dac_out;
    logic                   dac_valid;
    logic                   underrun;

    modport master (
        output in_valid, I_in, Q_in, cos_carrier, sin_carrier,
        input  in_ready, dac_out, dac_valid, underrun
    );

    modport slave (
        input  in_valid, I_in, Q_in, cos_carrier, sin_carrier,
        output in_ready, dac_out, dac_valid, underrun
    );
endinterface

// File: rtl/upmixer.sv
// I/Q upmixer: takes complex baseband at clk/R, interpolates each rail by R
// with a 3-stage CIC (combs at the low rate, zero-stuff, integrators at clk),
// scales by SHIFT, mixes with the external cos/sin carrier and produces one
// real DAC sample per enabled clk.
// Ports:
//   clk   system clock
//   rstn  asynchronous reset, active low
//   en    global enable; low freezes all state
//   bus   upmixer_if slave: baseband handshake, carrier in, DAC out
module upmixer #(
    parameter int NIN   = 16,
    parameter int NMAX  = 32,
    parameter int NOUT  = 16,
    parameter int R     = 20,
    parameter int SHIFT = 9
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     en,
    upmixer_if.slave bus
);

    localparam int CW = (R > 1) ? $clog2(R) : 1;
    localparam int BW = NIN + 1;     // scaled CIC output width
    localparam int PW = BW + 8 + 1;  // mixer product width incl. subtraction

    localparam logic signed [NMAX-1:0] B_MAX = {{(NMAX-NIN){1'b0}}, {NIN{1'b1}}};
    localparam logic signed [NMAX-1:0] B_MIN = {{(NMAX-NIN){1'b1}}, {NIN{1'b0}}};
    localparam logic signed [PW-1:0]   O_MAX = {{(PW-NOUT+1){1'b0}}, {(NOUT-1){1'b1}}};
    localparam logic signed [PW-1:0]   O_MIN = {{(PW-NOUT+1){1'b1}}, {(NOUT-1){1'b0}}};

    function automatic logic signed [BW-1:0] sat_b(input logic signed [NMAX-1:0] v);
        if (v > B_MAX)      return B_MAX[BW-1:0];
        else if (v < B_MIN) return B_MIN[BW-1:0];
        else                return v[BW-1:0];
    endfunction

    function automatic logic signed [NOUT-1:0] sat_out(input logic signed [PW-1:0] v);
        if (v > O_MAX)      return O_MAX[NOUT-1:0];
        else if (v < O_MIN) return O_MIN[NOUT-1:0];
        else                return v[NOUT-1:0];
    endfunction

    logic [CW-1:0]          cnt;
    logic                   in_ready_c;

    // Index 0 = I rail, index 1 = Q rail.
    logic signed [NMAX-1:0] x_p0     [2];
    logic signed [NMAX-1:0] y1       [2];
    logic signed [NMAX-1:0] y2       [2];
    logic signed [NMAX-1:0] y3       [2];
    logic signed [NMAX-1:0] z1       [2];
    logic signed [NMAX-1:0] z2       [2];
    logic signed [NMAX-1:0] z3       [2];
    logic signed [NMAX-1:0] comb_p1  [2];
    logic                   vld_p1;
    logic signed [NMAX-1:0] integ_in [2];
    logic signed [NMAX-1:0] i1_p2    [2];
    logic signed [NMAX-1:0] i2_p3    [2];
    logic signed [NMAX-1:0] i3_p4    [2];
    logic signed [NMAX-1:0] i3_sh    [2];
    logic signed [BW-1:0]   b_i;
    logic signed [BW-1:0]   b_q;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   prod_sh;
    logic signed [NOUT-1:0] dac_out_p5;
    logic                   vld_p5;

    assign in_ready_c   = en && (cnt == CW'(R - 1));
    assign bus.in_ready = in_ready_c;
    // A missing sample on the transfer cycle is replaced by zero, not stalled.
    assign bus.underrun = in_ready_c && !bus.in_valid;

    always_comb begin
        x_p0[0] = bus.in_valid ? {{(NMAX-NIN){bus.I_in[NIN-1]}}, bus.I_in} : '0;
        x_p0[1] = bus.in_valid ? {{(NMAX-NIN){bus.Q_in[NIN-1]}}, bus.Q_in} : '0;
        for (int r = 0; r < 2; r++) begin
            y1[r]       = x_p0[r] - z1[r];
            y2[r]       = y1[r] - z2[r];
            y3[r]       = y2[r] - z3[r];
            // Zero-stuffing: the comb result enters the integrators once.
            integ_in[r] = vld_p1 ? comb_p1[r] : '0;
            i3_sh[r]    = i3_p4[r] >>> SHIFT;
        end
        b_i     = sat_b(i3_sh[0]);
        b_q     = sat_b(i3_sh[1]);
        prod    = PW'(b_i) * PW'(bus.cos_carrier) - PW'(b_q) * PW'(bus.sin_carrier);
        prod_sh = prod >>> 7;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt        <= '0;
            vld_p1     <= 1'b0;
            vld_p5     <= 1'b0;
            dac_out_p5 <= '0;
            for (int r = 0; r < 2; r++) begin
                z1[r]      <= '0;
                z2[r]      <= '0;
                z3[r]      <= '0;
                comb_p1[r] <= '0;
                i1_p2[r]   <= '0;
                i2_p3[r]   <= '0;
                i3_p4[r]   <= '0;
            end
        end else begin
            vld_p5 <= en;
            if (en) begin
                cnt    <= (cnt == CW'(R - 1)) ? '0 : cnt + 1'b1;
                // p0 -> p1: low-rate comb, updated only on the transfer cycle
                vld_p1 <= in_ready_c;
                for (int r = 0; r < 2; r++) begin
                    if (in_ready_c) begin
                        z1[r]      <= x_p0[r];
                        z2[r]      <= y1[r];
                        z3[r]      <= y2[r];
                        comb_p1[r] <= y3[r];
                    end
                    // p1 -> p4: integrators, modular arithmetic in NMAX bits
                    i1_p2[r] <= i1_p2[r] + integ_in[r];
                    i2_p3[r] <= i2_p3[r] + i1_p2[r];
                    i3_p4[r] <= i3_p4[r] + i2_p3[r];
                end
                // p4 -> p5: scale, mix, saturate
                dac_out_p5 <= sat_out(prod_sh);
            end
        end
    end

    assign bus.dac_out   = dac_out_p5;
    assign bus.dac_valid = vld_p5;

endmodule

// File: tb/tb_upmixer.sv
module tb_upmixer;

    localparam int NIN  = 16;
    localparam int NOUT = 16;
    localparam int R    = 20;
    localparam int SH   = 9;
    localparam int HL   = 3 * R - 2;

    logic clk;
    logic rstn;
    logic en;

    upmixer_if #(.NIN(NIN), .NOUT(NOUT)) ifa ();
    upmixer_if #(.NIN(NIN), .NOUT(NOUT)) ifb ();

    upmixer #(.NIN(NIN), .NMAX(32), .NOUT(NOUT), .R(R), .SHIFT(SH)) dut (
        .clk(clk), .rstn(rstn), .en(en), .bus(ifa)
    );

    upmixer #(.NIN(NIN), .NMAX(32), .NOUT(NOUT), .R(R), .SHIFT(0)) dut0 (
        .clk(clk), .rstn(rstn), .en(en), .bus(ifb)
    );

    assign ifb.in_valid    = ifa.in_valid;
    assign ifb.I_in        = ifa.I_in;
    assign ifb.Q_in        = ifa.Q_in;
    assign ifb.cos_carrier = ifa.cos_carrier;
    assign ifb.sin_carrier = ifa.sin_carrier;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_chk  = 0;
    int     n_pass = 0;

    // Reference model state
    longint h [HL];
    longint hist_i [64];
    longint hist_q [64];
    int     hidx;
    int     mcnt;
    longint sbq_i [$];
    longint sbq_q [$];
    longint last_out;
    bit     imp_on;
    int     imp_j;
    longint imp_acc;

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic longint satw(input longint v, input int w);
        longint mx, mn;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -mx - 1;
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    function automatic longint mixv(input longint bi, input longint bq,
                                    input longint c, input longint s);
        return satw((bi * c - bq * s) >>> 7, NOUT);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 64; k++) begin
            hist_i[k] = 0;
            hist_q[k] = 0;
        end
        hidx = 0;
        mcnt = 0;
        sbq_i.delete();
        sbq_q.delete();
        // pipeline holds zeros for the first four enabled cycles
        for (int k = 0; k < 4; k++) begin
            sbq_i.push_back(0);
            sbq_q.push_back(0);
        end
        last_out = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        en   = 1'b0;
        rstn = 1'b0;
        #1;
        chk("rst_dac_out",   ifa.dac_out,   0);
        chk("rst_dac_valid", ifa.dac_valid, 0);
        chk("rst_in_ready",  ifa.in_ready,  0);
        chk("rst_underrun",  ifa.underrun,  0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic step(input bit e, input bit v, input int i, input int q,
                        input int c, input int s);
        bit     rdy;
        longint xi, xq, cvi, cvq, exp_o, exp0;
        @(negedge clk);
        en              = e;
        ifa.in_valid    = v;
        ifa.I_in        = i[15:0];
        ifa.Q_in        = q[15:0];
        ifa.cos_carrier = c[7:0];
        ifa.sin_carrier = s[7:0];
        #1;
        rdy = e && (mcnt == R - 1);
        chk("in_ready", ifa.in_ready, rdy);
        chk("underrun", ifa.underrun, rdy && !v);
        if (e) begin
            xi = (rdy && v) ? longint'(i) : 0;
            xq = (rdy && v) ? longint'(q) : 0;
            hist_i[hidx & 63] = xi;
            hist_q[hidx & 63] = xq;
            cvi = 0;
            cvq = 0;
            for (int k = 0; k < HL; k++) begin
                cvi += h[k] * hist_i[(hidx - k) & 63];
                cvq += h[k] * hist_q[(hidx - k) & 63];
            end
            hidx++;
            sbq_i.push_back(satw(cvi >>> SH, NIN + 1));
            sbq_q.push_back(satw(cvq >>> SH, NIN + 1));
            mcnt = (mcnt == R - 1) ? 0 : mcnt + 1;
        end
        @(posedge clk);
        #1;
        chk("dac_valid", ifa.dac_valid, e);
        if (e) begin
            exp_o    = mixv(sbq_i.pop_front(), sbq_q.pop_front(), c, s);
            last_out = exp_o;
            chk("dac_out", ifa.dac_out, exp_o);
        end else begin
            chk("dac_hold", ifa.dac_out, last_out);
        end
        if (imp_on) begin
            imp_j++;
            exp0 = (imp_j >= 5 && imp_j - 5 < HL) ? mixv(h[imp_j - 5], 0, c, s) : 0;
            chk("imp_dac_out", ifb.dac_out, exp0);
            imp_acc += longint'(dut0.b_i);
        end
    endtask

    initial begin
        // boxcar^3 impulse response of the interpolator
        for (int k = 0; k < HL; k++) h[k] = 0;
        for (int a = 0; a < R; a++)
            for (int b = 0; b < R; b++)
                for (int d = 0; d < R; d++)
                    h[a + b + d] += 1;

        rstn            = 1'b0;
        en              = 1'b0;
        ifa.in_valid    = 1'b0;
        ifa.I_in        = '0;
        ifa.Q_in        = '0;
        ifa.cos_carrier = '0;
        ifa.sin_carrier = '0;
        imp_on          = 1'b0;
        imp_j           = 0;
        imp_acc         = 0;

        // cadence with in_valid always high
        do_reset();
        for (int k = 0; k < 60; k++) step(1, 1, 0, 0, 127, 0);

        // DC on I settles to 774
        for (int k = 0; k < 200; k++) step(1, 1, 1000, 0, 127, 0);
        chk("dc_774", ifa.dac_out, 774);

        // freeze mid-stream, resume, then reset pulse and restarted cadence
        for (int k = 0; k < 7; k++) step(0, 1, 1000, 0, 127, 0);
        chk("frozen_774", ifa.dac_out, 774);
        for (int k = 0; k < 23; k++) step(1, 1, -500, 300, 100, -90);
        do_reset();
        for (int k = 0; k < 45; k++) step(1, 1, 0, 0, 127, 0);

        // unit impulse on I into the SHIFT=0 instance
        do_reset();
        for (int k = 0; k < R - 1; k++) step(1, 1, 1, 0, 127, 0);
        imp_on = 1'b1;
        step(1, 1, 1, 0, 127, 0);
        for (int k = 0; k < 80; k++) step(1, 1, 0, 0, 127, 0);
        imp_on = 1'b0;
        chk("imp_sum_8000", imp_acc, 8000);

        // full-scale inputs clamp positive
        do_reset();
        for (int k = 0; k < 200; k++) step(1, 1, 32767, -32768, 127, 127);
        chk("clamp_pos", ifa.dac_out, 32767);

        // in_valid held low: underrun with every in_ready, output stays 0
        do_reset();
        for (int k = 0; k < 60; k++) step(1, 0, 1234, -321, 127, 50);
        chk("underrun_zero_out", ifa.dac_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
